// File: rtl/stereo_line_interleaver_if.sv
// stereo_line_interleaver_if: AXI4-Stream bundle for the camera inputs and the interleaved output.
interface stereo_line_interleaver_if #(parameter int DATA_W = 32);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;
    logic              tdest;
    modport master (output tdata, tvalid, tuser, tlast, tdest, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/stereo_line_interleaver.sv
// stereo_line_interleaver: merges left/right camera streams line by line (L0,R0,L1,R1,...),
// realigning on SOF and buffering the output through a 2-entry skid register.
module stereo_line_interleaver #(
    parameter int LINES  = 480,
    parameter int DATA_W = 32
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    stereo_line_interleaver_if.slave         s0,
    stereo_line_interleaver_if.slave         s1,
    stereo_line_interleaver_if.master        m,
    output logic                             sync_err,
    output logic [15:0]                      resync_cnt
);
    localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int BW = DATA_W + 3;
    localparam logic [LW-1:0] LAST = LW'(LINES - 1);
    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;
    state_t        state_q, state_d;
    logic [LW-1:0] line_q, line_d;
    logic          beat0_q, beat0_d, run_q;
    logic [1:0]    cnt_q, cnt_d;
    logic [BW-1:0] head_q, head_d, tail_q, tail_d, in_beat;
    logic          sync_err_q, sync_err_d;
    logic [15:0]   resync_q, resync_d;
    logic          first, space, push, pop, err, in_last, sof_pair;
    always_comb begin
        first     = (line_q == '0) && beat0_q;
        space     = cnt_q != 2'd2;
        // a tuser beat is only accepted as the frame's opening beat; anywhere else it is held
        s0.tready = run_q && ((state_q == SYNC) ? !s0.tuser : (state_q == LEFT) && space && (first || !s0.tuser));
        s1.tready = run_q && ((state_q == SYNC) ? !s1.tuser : (state_q == RIGHT) && space && (first || !s1.tuser));
        err       = ((state_q == LEFT) && s0.tvalid && s0.tuser && !first) ||
                    ((state_q == RIGHT) && s1.tvalid && s1.tuser && !first);
        push      = ((state_q == LEFT) && s0.tvalid && s0.tready) || ((state_q == RIGHT) && s1.tvalid && s1.tready);
        in_last   = (state_q == RIGHT) ? s1.tlast : s0.tlast;
        in_beat   = (state_q == RIGHT) ? {1'b1, first, s1.tlast, s1.tdata} : {1'b0, first, s0.tlast, s0.tdata};
        sof_pair  = run_q && s0.tvalid && s0.tuser && s1.tvalid && s1.tuser;
        pop       = (cnt_q != 2'd0) && m.tready;
        cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
        head_d    = (pop && cnt_q == 2'd2) ? tail_q : (push && (cnt_q == 2'd0 || pop)) ? in_beat : head_q;
        tail_d    = (push && cnt_q == 2'd1 && !pop) ? in_beat : tail_q;
        state_d   = state_q;
        line_d    = line_q;
        beat0_d   = beat0_q;
        if (state_q == SYNC) begin
            state_d = sof_pair ? LEFT : SYNC;
            line_d  = '0;
            beat0_d = 1'b1;
        end else if (err) begin
            state_d = SYNC;
        end else if (push) begin
            beat0_d = in_last;
            if (in_last && state_q == LEFT) state_d = RIGHT;
            if (in_last && state_q == RIGHT) begin
                state_d = (line_q == LAST) ? SYNC : LEFT;
                line_d  = (line_q == LAST) ? '0 : line_q + LW'(1);
            end
        end
        sync_err_d = err;
        resync_d   = (err && resync_q != 16'hFFFF) ? resync_q + 16'd1 : resync_q;
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= SYNC;
            line_q     <= '0;
            beat0_q    <= 1'b1;
            run_q      <= 1'b0;
            cnt_q      <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
            sync_err_q <= 1'b0;
            resync_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            beat0_q    <= beat0_d;
            run_q      <= 1'b1;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            sync_err_q <= sync_err_d;
            resync_q   <= resync_d;
        end
    end
    assign m.tvalid = cnt_q != 2'd0;
    assign {m.tdest, m.tuser, m.tlast, m.tdata} = head_q;
    assign sync_err   = sync_err_q;
    assign resync_cnt = resync_q;
endmodule

// File: tb/tb_stereo_line_interleaver.sv
// tb_stereo_line_interleaver: directed frames into a LINES=4 and a LINES=2 instance, output checked
// beat by beat against a hand-built expected sequence.
module tb_stereo_line_interleaver;
    typedef struct packed {logic u; logic l; logic [31:0] d;} in_t;
    typedef struct packed {logic dst; logic u; logic l; logic [31:0] d;} out_t;
    logic aclk = 1'b0, aresetn = 1'b0, sel = 1'b0, mr = 1'b1, v0 = 1'b0, v1 = 1'b0;
    logic prev_stall = 1'b0, hold_chk = 1'b0;
    in_t  h0 = '0, h1 = '0;
    out_t prev = '0;
    in_t  q0[$], q1[$];
    out_t expq[$], outq[$];
    int checks = 0, failures = 0, errs = 0, rmode = 0, last_n = 0;
    always #5 aclk = ~aclk;
    stereo_line_interleaver_if #(.DATA_W(32)) a_s0(), a_s1(), a_m(), b_s0(), b_s1(), b_m();
    logic a_err, b_err;
    logic [15:0] a_rc, b_rc;
    stereo_line_interleaver #(.LINES(4), .DATA_W(32)) dut_a (.aclk(aclk), .aresetn(aresetn),
        .s0(a_s0), .s1(a_s1), .m(a_m), .sync_err(a_err), .resync_cnt(a_rc));
    stereo_line_interleaver #(.LINES(2), .DATA_W(32)) dut_b (.aclk(aclk), .aresetn(aresetn),
        .s0(b_s0), .s1(b_s1), .m(b_m), .sync_err(b_err), .resync_cnt(b_rc));
    assign {a_s0.tvalid, a_s0.tuser, a_s0.tlast, a_s0.tdata, a_s0.tdest} = {v0 & ~sel, h0, 1'b0};
    assign {a_s1.tvalid, a_s1.tuser, a_s1.tlast, a_s1.tdata, a_s1.tdest} = {v1 & ~sel, h1, 1'b0};
    assign {b_s0.tvalid, b_s0.tuser, b_s0.tlast, b_s0.tdata, b_s0.tdest} = {v0 & sel, h0, 1'b0};
    assign {b_s1.tvalid, b_s1.tuser, b_s1.tlast, b_s1.tdata, b_s1.tdest} = {v1 & sel, h1, 1'b0};
    assign a_m.tready = mr & ~sel;
    assign b_m.tready = mr & sel;
    logic r0, r1, mv, serr;
    logic [15:0] rc;
    out_t ob;
    assign r0   = sel ? b_s0.tready : a_s0.tready;
    assign r1   = sel ? b_s1.tready : a_s1.tready;
    assign mv   = sel ? b_m.tvalid : a_m.tvalid;
    assign ob   = sel ? {b_m.tdest, b_m.tuser, b_m.tlast, b_m.tdata} : {a_m.tdest, a_m.tuser, a_m.tlast, a_m.tdata};
    assign serr = sel ? b_err : a_err;
    assign rc   = sel ? b_rc : a_rc;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic in_t mk(int f, int s, int ln, int b, int nb);
        in_t x;
        x.u = (ln == 0 && b == 0);
        x.l = (b == nb - 1);
        x.d = 32'((f << 16) | (s << 12) | (ln << 8) | b);
        return x;
    endfunction

    // left stream is cut after cut_beat beats of cut_line; full frames pass cut_line = lines
    task automatic add_frame(int f, int lines, int nb, int cut_line, int cut_beat, bit with_exp);
        for (int ln = 0; ln < lines; ln++)
            for (int b = 0; b < nb; b++) begin
                if (ln < cut_line || (ln == cut_line && b < cut_beat)) q0.push_back(mk(f, 0, ln, b, nb));
                q1.push_back(mk(f, 1, ln, b, nb));
            end
        if (with_exp)
            for (int ln = 0; ln < lines && ln <= cut_line; ln++)
                for (int s = 0; s < 2; s++)
                    for (int b = 0; b < nb; b++)
                        if (ln < cut_line || (s == 0 && b < cut_beat)) expq.push_back({s[0], mk(f, s, ln, b, nb)});
    endtask

    task automatic cycle();
        logic f0, f1;
        @(negedge aclk);
        v0 = q0.size() != 0;
        v1 = q1.size() != 0;
        if (v0) h0 = q0[0];
        if (v1) h1 = q1[0];
        mr = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (prev_stall) chk("stable", {mv, ob}, {1'b1, prev});
        if (hold_chk && v0 && h0.u && v1 && !h1.u) chk("left_hold", r0, 0);
        if (serr) errs++;
        prev_stall = mv && !mr;
        prev = ob;
        if (mv && mr) outq.push_back(ob);
        f0 = v0 && r0;
        f1 = v1 && r1;
        @(posedge aclk);
        if (f0) void'(q0.pop_front());
        if (f1) void'(q1.pop_front());
    endtask

    task automatic run_frames(string tag, int budget);
        last_n = 0;
        while (outq.size() < expq.size() && last_n < budget) begin
            cycle();
            last_n++;
        end
        repeat (8) cycle();
        chk({tag, "_count"}, outq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < outq.size(); i++) chk(tag, outq[i], expq[i]);
        outq.delete();
        expq.delete();
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_tvalid"}, mv, 0);
        chk({tag, "_beat"}, ob, 0);
        chk({tag, "_sync_err"}, serr, 0);
        chk({tag, "_resync_cnt"}, rc, 0);
        chk({tag, "_s0_tready"}, r0, 0);
        chk({tag, "_s1_tready"}, r1, 0);
    endtask

    initial begin
        // reset with junk presented on both inputs, then drain on release
        q0.push_back(mk(99, 0, 1, 3, 8));
        q1.push_back(mk(99, 1, 1, 3, 8));
        repeat (2) cycle();
        #1;
        chk_reset_vals("reset");
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (3) cycle();
        chk("drain_after_release", q0.size() + q1.size(), 0);
        // two aligned frames at full rate
        add_frame(0, 4, 8, 4, 0, 1'b1);
        add_frame(1, 4, 8, 4, 0, 1'b1);
        run_frames("aligned", 400);
        chk("aligned_rate", (last_n <= 136), 1);
        chk("aligned_errs", errs, 0);
        // right stream starts mid-line, left SOF waits
        for (int b = 0; b < 3; b++) q1.push_back(mk(2, 1, 3, b + 5, 8));
        add_frame(2, 4, 8, 4, 0, 1'b1);
        hold_chk = 1'b1;
        run_frames("late_right", 400);
        hold_chk = 1'b0;
        chk("late_right_errs", errs, 0);
        chk("late_right_rc", rc, 0);
        // unexpected left SOF at line 2 beat 5 starts the next frame
        add_frame(10, 4, 8, 2, 5, 1'b1);
        add_frame(11, 4, 8, 4, 0, 1'b1);
        run_frames("resync", 600);
        chk("resync_pulses", errs, 1);
        chk("resync_cnt", rc, 1);
        // random downstream backpressure
        rmode = 1;
        for (int f = 3; f < 6; f++) add_frame(f, 4, 8, 4, 0, 1'b1);
        run_frames("backpressure", 2000);
        rmode = 0;
        // reset pulse during the first right line
        add_frame(20, 4, 8, 4, 0, 1'b0);
        while (outq.size() < 11 && last_n < 1000) begin
            cycle();
            last_n++;
        end
        chk("pre_reset_progress", (outq.size() >= 11), 1);
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk_reset_vals("mid_reset");
        @(negedge aclk);
        #1;
        aresetn = 1'b1;
        outq.delete();
        prev_stall = 1'b0;
        add_frame(21, 4, 8, 4, 0, 1'b1);
        run_frames("after_reset", 600);
        // one-beat lines on the LINES=2 instance
        sel = 1'b1;
        errs = 0;
        add_frame(30, 2, 1, 2, 0, 1'b1);
        run_frames("one_beat", 100);
        chk("one_beat_errs", errs, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule

// File: doc/stereo_line_interleaver.md
STEREO_LINE_INTERLEAVER -- requirements
Module: stereo_line_interleaver

Interface
REQ-001 Parameter LINES, default 480: active lines per frame per camera.
REQ-002 Parameter DATA_W, default 32: AXI4-Stream tdata width.
REQ-003 aclk  in  1: single clock for all logic.
REQ-004 aresetn  in  1: reset, asynchronous assert, active-low.
REQ-005 s0_axis_tdata/tvalid/tuser/tlast  in  DATA_W/1/1/1: left stream, tuser=SOF, tlast=EOL.
REQ-006 s0_axis_tready  out  1: left-stream ready.
REQ-007 s1_axis_tdata/tvalid/tuser/tlast  in  DATA_W/1/1/1: right stream, same semantics.
REQ-008 s1_axis_tready  out  1: right-stream ready.
REQ-009 m_axis_tdata/tvalid/tuser/tlast  out  DATA_W/1/1/1: interleaved output stream.
REQ-010 m_axis_tdest  out  1: source of the current beat, 0=left, 1=right.
REQ-011 m_axis_tready  in  1: downstream ready.
REQ-012 sync_err  out  1: one-cycle pulse on each frame-alignment loss.
REQ-013 resync_cnt  out  16: count of sync_err pulses, saturating at 0xFFFF.

Function
REQ-014 FSM states SYNC, LEFT, RIGHT; transfers follow standard AXIS rules, a beat moves when tvalid&tready.
REQ-015 SYNC: any input beat with tuser=0 is drained (tready=1, discarded); an input presenting tuser=1 is held (tready=0).
REQ-016 SYNC -> LEFT when both inputs present tvalid&tuser=1 in the same cycle; the line counter clears to 0.
REQ-017 LEFT: s0 beats are forwarded with tdest=0 and s1_axis_tready=0; on the s0 beat with tlast=1, go to RIGHT.
REQ-018 RIGHT: s1 beats are forwarded with tdest=1 and s0_axis_tready=0; on the s1 beat with tlast=1, increment the line counter and go to LEFT, or go to SYNC if the counter reaches LINES-1.
REQ-019 m_axis_tuser is 1 only on the first forwarded left beat and the first forwarded right beat of a frame.
REQ-020 m_axis_tlast is a copy of the forwarded beat's tlast; a one-beat line (tuser=tlast=1) is legal.
REQ-021 In LEFT or RIGHT, a tuser=1 beat on the active input at any point other than line 0 beat 0: do not consume it, pulse sync_err, increment resync_cnt, go to SYNC; the held beat then serves as that input's SOF.
REQ-022 Output goes through a 2-entry skid register: m_axis_* are driven from flops only; input tready depends only on registered state and skid occupancy, with no combinational path from m_axis_tready.
REQ-023 Latency: an accepted input beat appears on m_axis one cycle later when the skid is empty and m_axis_tready=1.
REQ-024 Sustained throughput is 1 beat/cycle while m_axis_tready=1; no beat is dropped or duplicated under arbitrary m_axis_tready patterns.
REQ-025 m_axis_tvalid, once asserted, holds with stable tdata/tuser/tlast/tdest until accepted.
REQ-026 Line counter width is ceil(log2(LINES)); it never exceeds LINES-1.
REQ-027 Beats already in the skid at a sync_err are still delivered; no new beat enters the skid until SYNC exits.

Reset
REQ-028 While aresetn=0: state=SYNC, line counter=0, skid empty, m_axis_tvalid=0, m_axis_tuser=0, m_axis_tlast=0, m_axis_tdest=0, m_axis_tdata=0, sync_err=0, resync_cnt=0, s0/s1_axis_tready=0.
REQ-029 On the first aclk edge after deassertion, the block enters SYNC with drain behaviour active.
REQ-030 Reset asserted mid-line discards all skid contents; no partial line is emitted after release.

Verification
REQ-031 LINES=4, two 4x8-beat frames on both inputs, m_axis_tready=1 -> output order L0,R0,L1,R1..R3 per frame; tuser on beat 0 of L0 and R0 only; 8 tlast per frame; tdest matches source.
REQ-032 Right stream starts 3 beats mid-line before its SOF, left SOF already waiting -> 3 right beats drained, left held (s0_axis_tready=0), output starts with left SOF; sync_err stays 0.
REQ-033 Unexpected s0 tuser=1 at line 2 beat 5 -> sync_err pulses once, resync_cnt=1, that beat is not consumed, and it becomes the next frame's left SOF.
REQ-034 m_axis_tready random at 50% over 3 frames -> output beat sequence identical to the tready=1 run and tvalid/tdata stable while stalled.
REQ-035 aresetn pulsed low for 1 cycle mid-RIGHT line -> all outputs return to REQ-028 values, and the next output beat is a left SOF after both SOFs arrive.
REQ-036 One-beat lines (tuser=tlast=1 then tlast=1 each line), LINES=2 -> output L,R,L,R with tuser on the first two beats only.
